// File: rtl/alu_pkg.sv
// Shared opcode encodings and controller state type for the sequential ALU.
// The opcode space is fully decoded, so every 3-bit value names an operation.
package alu_pkg;

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_MOD  = 3'b100;
    localparam logic [2:0] OP_SHL1 = 3'b101;
    localparam logic [2:0] OP_SHR1 = 3'b110;
    localparam logic [2:0] OP_GT   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DIV  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle of the sequential ALU: operand handshake in, result handshake out.
// The master drives operations and accepts results; the slave is the ALU itself.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out;
    logic             zero;
    logic             err;

    modport master (
        output in_valid, a, b, sel, out_ready,
        input  in_ready, out_valid, out, zero, err
    );

    modport slave (
        input  in_valid, a, b, sel, out_ready,
        output in_ready, out_valid, out, zero, err
    );
endinterface

// File: rtl/alu_div_iter.sv
// Restoring divider producing one quotient bit per cycle. The first bit is resolved on the
// start edge, so done pulses WIDTH-1 cycles later with quotient/remainder already settled.
module alu_div_iter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] d_r;
    logic [CW-1:0]    cnt_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH:0]   step_s;

    // One restoring step: returns {quotient bit, new remainder}; rem < dv keeps the result in WIDTH bits.
    function automatic logic [WIDTH:0] div_step(input logic [WIDTH-1:0] rem,
                                                input logic bit_in,
                                                input logic [WIDTH-1:0] dv);
        logic [WIDTH:0] trial;
        logic [WIDTH:0] diff;
        trial = {rem, bit_in};
        diff  = trial - {1'b0, dv};
        if (trial >= {1'b0, dv}) begin
            return {1'b1, diff[WIDTH-1:0]};
        end else begin
            return {1'b0, trial[WIDTH-1:0]};
        end
    endfunction

    // Select the step operands: fresh operands on start, running state otherwise.
    always_comb begin
        step_s = {(WIDTH+1){1'b0}};
        if (start) begin
            step_s = div_step({WIDTH{1'b0}}, dividend[WIDTH-1], divisor);
        end else begin
            step_s = div_step(rem_r, q_r[WIDTH-1], d_r);
        end
    end

    // Shift register holds remaining dividend bits at the top and quotient bits at the bottom.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r    <= {WIDTH{1'b0}};
            rem_r  <= {WIDTH{1'b0}};
            d_r    <= {WIDTH{1'b0}};
            cnt_r  <= {CW{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (start) begin
                d_r    <= divisor;
                rem_r  <= step_s[WIDTH-1:0];
                q_r    <= {dividend[WIDTH-2:0], step_s[WIDTH]};
                cnt_r  <= CNT_INIT;
                busy_r <= 1'b1;
            end else if (busy_r) begin
                rem_r <= step_s[WIDTH-1:0];
                q_r   <= {q_r[WIDTH-2:0], step_s[WIDTH]};
                cnt_r <= cnt_r - CW'(1);
                if (cnt_r == CNT_LAST) begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end
            end
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign quotient  = q_r;
    assign remainder = rem_r;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops go straight to DONE, non-zero div/mod detour through
// the iterative divider. One operation is in flight at a time; all outputs are registered.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);
    state_t           state_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH:0]   out_r;
    logic             zero_r;
    logic             err_r;
    logic             op_mod_r;

    logic [WIDTH:0]   res_s;
    logic [WIDTH:0]   a_x_s;
    logic [WIDTH:0]   b_x_s;
    logic [WIDTH:0]   div_res_s;
    logic             is_div_s;
    logic             b_zero_s;
    logic             div_start_s;
    logic             div_busy_s;
    logic             div_done_s;
    logic [WIDTH-1:0] quo_s;
    logic [WIDTH-1:0] rem_s;

    // Single-cycle result; the div/mod entries only matter for the divide-by-zero case.
    always_comb begin
        a_x_s = {1'b0, bus.a};
        b_x_s = {1'b0, bus.b};
        res_s = {(WIDTH+1){1'b0}};
        case (bus.sel)
            OP_PASS: res_s = a_x_s;
            OP_ADD:  res_s = a_x_s + b_x_s;
            OP_SUB:  res_s = a_x_s - b_x_s;
            OP_DIV:  res_s = {1'b0, {WIDTH{1'b1}}};
            OP_MOD:  res_s = a_x_s;
            OP_SHL1: res_s = {bus.a, 1'b0};
            OP_SHR1: res_s = {2'b00, bus.a[WIDTH-1:1]};
            OP_GT: begin
                if (bus.a > bus.b) begin
                    res_s = {{WIDTH{1'b0}}, 1'b1};
                end else begin
                    res_s = {(WIDTH+1){1'b0}};
                end
            end
            default: res_s = {(WIDTH+1){1'b0}};
        endcase
    end

    // Operation classification and divider launch on accept.
    always_comb begin
        is_div_s    = (bus.sel == OP_DIV) || (bus.sel == OP_MOD);
        b_zero_s    = (bus.b == {WIDTH{1'b0}});
        div_start_s = (state_r == IDLE) && bus.in_valid && is_div_s && !b_zero_s;
        if (op_mod_r) begin
            div_res_s = {1'b0, rem_s};
        end else begin
            div_res_s = {1'b0, quo_s};
        end
    end

    alu_div_iter #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start_s),
        .dividend  (bus.a),
        .divisor   (bus.b),
        .busy      (div_busy_s),
        .done      (div_done_s),
        .quotient  (quo_s),
        .remainder (rem_s)
    );

    // Controller FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_r       <= {(WIDTH+1){1'b0}};
            zero_r      <= 1'b0;
            err_r       <= 1'b0;
            op_mod_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        in_ready_r <= 1'b0;
                        if (is_div_s && !b_zero_s) begin
                            state_r  <= DIV;
                            op_mod_r <= (bus.sel == OP_MOD);
                        end else begin
                            state_r     <= DONE;
                            out_valid_r <= 1'b1;
                            out_r       <= res_s;
                            zero_r      <= (res_s == {(WIDTH+1){1'b0}});
                            err_r       <= is_div_s && b_zero_s;
                        end
                    end
                end
                DIV: begin
                    if (div_done_s) begin
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                        out_r       <= div_res_s;
                        zero_r      <= (div_res_s == {(WIDTH+1){1'b0}});
                        err_r       <= 1'b0;
                    end else if (!div_busy_s) begin
                        // Divider lost its operation: recover to IDLE rather than wait forever.
                        state_r    <= IDLE;
                        in_ready_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out       = out_r;
    assign bus.zero      = zero_r;
    assign bus.err       = err_r;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed vectors, randomized ops against an
// integer reference model, result hold, back-to-back scoreboard and reset abort.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W    = 8;
    localparam int MASK = (1 << (W + 1)) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: returns {err, out} from plain integer arithmetic.
    function automatic logic [W+1:0] ref_alu(input int unsigned av, input int unsigned bv,
                                             input int unsigned s);
        int unsigned r;
        logic        e;
        e = 1'b0;
        case (s)
            0: r = av;
            1: r = av + bv;
            2: r = (av + (1 << (W + 1)) - bv) & MASK;
            3: begin if (bv == 0) begin r = (1 << W) - 1; e = 1'b1; end else r = av / bv; end
            4: begin if (bv == 0) begin r = av; e = 1'b1; end else r = av % bv; end
            5: r = av * 2;
            6: r = av / 2;
            default: r = (av > bv) ? 1 : 0;
        endcase
        return {e, r[W:0]};
    endfunction

    function automatic int ref_lat(input int unsigned bv, input int unsigned s);
        return ((s == 3 || s == 4) && bv != 0) ? W + 1 : 1;
    endfunction

    task automatic wait_ready();
        int w = 0;
        while (!bus.in_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        if (!bus.in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_ready: in_ready still %b after %0d cycles, required 1", bus.in_ready, w);
        end
    endtask

    // Issue one op, measure accept-to-valid latency, collect result and consume it.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] s,
                          output logic [W:0] o, output logic z, output logic e,
                          output int lat, output logic ir_seen);
        wait_ready();
        bus.in_valid = 1'b1; bus.a = a; bus.b = b; bus.sel = s;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1; ir_seen = 1'b0;
        while (!bus.out_valid && lat < 60) begin
            if (bus.in_ready) ir_seen = 1'b1;
            @(posedge clk); #1; lat++;
        end
        o = bus.out; z = bus.zero; e = bus.err;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        if (bus.out !== 9'h000) begin n_bad++; $display("FAIL reset_out: got %h want 000", bus.out); end
        if (bus.zero !== 1'b0) begin n_bad++; $display("FAIL reset_zero: got %b want 0", bus.zero); end
        if (bus.err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus.err); end
        n_cmp += 5;
        rst = 1'b0;
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   s;
        logic [W:0]   o;
        logic         z;
        logic         e;
        int           lat;
    } vec_t;

    task automatic test_directed();
        vec_t v[10];
        logic [W:0] o; logic z, e, irs; int lat;
        v = '{
            '{8'd200, 8'd100, OP_ADD,  9'h12C, 1'b0, 1'b0, 1},
            '{8'd5,   8'd7,   OP_SUB,  9'h1FE, 1'b0, 1'b0, 1},
            '{8'h81,  8'd0,   OP_SHL1, 9'h102, 1'b0, 1'b0, 1},
            '{8'd3,   8'd3,   OP_GT,   9'h000, 1'b1, 1'b0, 1},
            '{8'd200, 8'd7,   OP_DIV,  9'd28,  1'b0, 1'b0, 9},
            '{8'd200, 8'd7,   OP_MOD,  9'd4,   1'b0, 1'b0, 9},
            '{8'd9,   8'd0,   OP_DIV,  9'h0FF, 1'b0, 1'b1, 1},
            '{8'd9,   8'd0,   OP_MOD,  9'd9,   1'b0, 1'b1, 1},
            '{8'hA5,  8'd3,   OP_SHR1, 9'h052, 1'b0, 1'b0, 1},
            '{8'd14,  8'd7,   OP_MOD,  9'd0,   1'b1, 1'b0, 9}
        };
        foreach (v[i]) begin
            run_op(v[i].a, v[i].b, v[i].s, o, z, e, lat, irs);
            n_cmp += 5;
            if (o !== v[i].o) begin n_bad++; $display("FAIL dir%0d_out: got %h want %h", i, o, v[i].o); end
            if (z !== v[i].z) begin n_bad++; $display("FAIL dir%0d_zero: got %b want %b", i, z, v[i].z); end
            if (e !== v[i].e) begin n_bad++; $display("FAIL dir%0d_err: got %b want %b", i, e, v[i].e); end
            if (lat !== v[i].lat) begin n_bad++; $display("FAIL dir%0d_lat: got %0d want %0d", i, lat, v[i].lat); end
            if (irs !== 1'b0) begin n_bad++; $display("FAIL dir%0d_in_ready: got high while busy, want 0", i); end
        end
    endtask

    task automatic test_random();
        logic [W:0] o; logic z, e, irs; int lat;
        logic [W-1:0] a, b; logic [2:0] s; logic [W+1:0] exp;
        for (int i = 0; i < 150; i++) begin
            a = W'($urandom);
            b = ($urandom_range(0, 5) == 0) ? 8'd0 : W'($urandom);
            s = 3'($urandom_range(0, 7));
            exp = ref_alu(a, b, s);
            run_op(a, b, s, o, z, e, lat, irs);
            n_cmp += 4;
            if (o !== exp[W:0]) begin n_bad++; $display("FAIL rnd_out sel=%0d a=%0d b=%0d: got %h want %h", s, a, b, o, exp[W:0]); end
            if (z !== (exp[W:0] == 0)) begin n_bad++; $display("FAIL rnd_zero sel=%0d: got %b want %b", s, z, exp[W:0] == 0); end
            if (e !== exp[W+1]) begin n_bad++; $display("FAIL rnd_err sel=%0d b=%0d: got %b want %b", s, b, e, exp[W+1]); end
            if (lat != ref_lat(b, s)) begin n_bad++; $display("FAIL rnd_lat sel=%0d b=%0d: got %0d want %0d", s, b, lat, ref_lat(b, s)); end
        end
    endtask

    task automatic test_hold();
        int w = 0;
        wait_ready();
        bus.in_valid = 1'b1; bus.a = 8'd3; bus.b = 8'd3; bus.sel = OP_GT;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        while (!bus.out_valid && w < 20) begin @(posedge clk); #1; w++; end
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = 1'b1; bus.a = W'($urandom); bus.b = 8'd1; bus.sel = OP_ADD;
            n_cmp += 5;
            if (bus.out !== 9'h000) begin n_bad++; $display("FAIL hold_out c%0d: got %h want 000", c, bus.out); end
            if (bus.zero !== 1'b1) begin n_bad++; $display("FAIL hold_zero c%0d: got %b want 1", c, bus.zero); end
            if (bus.err !== 1'b0) begin n_bad++; $display("FAIL hold_err c%0d: got %b want 0", c, bus.err); end
            if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL hold_valid c%0d: got %b want 1", c, bus.out_valid); end
            if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL hold_in_ready c%0d: got %b want 0", c, bus.in_ready); end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL release_in_ready_early: got %b want 0", bus.in_ready); end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        n_cmp += 2;
        if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL release_in_ready: got %b want 1", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL release_out_valid: got %b want 0", bus.out_valid); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL ignored_pulses: out_valid %b want 0", bus.out_valid); end
    endtask

    // Free-running random traffic on both handshakes, checked through an in-order scoreboard.
    task automatic test_back_to_back();
        logic [W+1:0] q[$];
        logic [W+1:0] exp;
        logic overlap = 1'b0;
        int got = 0;
        for (int c = 0; c < 400; c++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.a         = W'($urandom);
            bus.b         = ($urandom_range(0, 6) == 0) ? 8'd0 : W'($urandom);
            bus.sel       = 3'($urandom_range(0, 7));
            bus.out_ready = ($urandom_range(0, 9) < 7);
            if (bus.in_ready && bus.out_valid) overlap = 1'b1;
            if (bus.out_valid && bus.out_ready) begin
                n_cmp++; got++;
                if (q.size() == 0) begin
                    n_bad++; $display("FAIL b2b_spurious: result %h with no pending op", bus.out);
                end else begin
                    exp = q.pop_front();
                    if ({bus.err, bus.out} !== exp || bus.zero !== (exp[W:0] == 0)) begin
                        n_bad++;
                        $display("FAIL b2b_result: got err=%b out=%h zero=%b want err=%b out=%h", bus.err, bus.out, bus.zero, exp[W+1], exp[W:0]);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) q.push_back(ref_alu(bus.a, bus.b, bus.sel));
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        for (int c = 0; c < 30 && q.size() != 0; c++) begin
            if (bus.out_valid) begin
                exp = q.pop_front();
                n_cmp++; got++;
                if ({bus.err, bus.out} !== exp) begin n_bad++; $display("FAIL b2b_drain: got %h want %h", {bus.err, bus.out}, exp); end
            end
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b0;
        n_cmp += 3;
        if (q.size() != 0) begin n_bad++; $display("FAIL b2b_pending: %0d results never delivered, want 0", q.size()); end
        if (overlap) begin n_bad++; $display("FAIL b2b_overlap: in_ready and out_valid both 1, want never"); end
        if (got < 20) begin n_bad++; $display("FAIL b2b_throughput: %0d results, want at least 20", got); end
    endtask

    task automatic test_reset_abort();
        logic [W:0] o; logic z, e, irs; int lat;
        logic seen = 1'b0;
        wait_ready();
        bus.in_valid = 1'b1; bus.a = 8'd200; bus.b = 8'd7; bus.sel = OP_DIV;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp += 2;
        if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL abort_out_valid: got %b want 0", bus.out_valid); end
        if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL abort_in_ready: got %b want 1", bus.in_ready); end
        for (int c = 0; c < 12; c++) begin
            if (bus.out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (seen) begin n_bad++; $display("FAIL abort_discard: stale result %h presented, want none", bus.out); end
        run_op(8'd1, 8'd1, OP_ADD, o, z, e, lat, irs);
        n_cmp += 2;
        if (o !== 9'd2) begin n_bad++; $display("FAIL abort_add: got %h want 002", o); end
        if (lat != 1) begin n_bad++; $display("FAIL abort_add_lat: got %0d want 1", lat); end
        // Reset while a result waits in DONE also drops it.
        wait_ready();
        bus.in_valid = 1'b1; bus.a = 8'd10; bus.b = 8'd20; bus.sel = OP_ADD;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp += 2;
        if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL done_rst_valid: got %b want 0", bus.out_valid); end
        if (bus.out !== 9'h000) begin n_bad++; $display("FAIL done_rst_out: got %h want 000", bus.out); end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sel = 3'b000; bus.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_hold();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  operand/opcode presented.
REQ-005 in_ready  output  1  block can accept a new operation.
REQ-006 a  input  WIDTH  operand A, unsigned.
REQ-007 b  input  WIDTH  operand B, unsigned.
REQ-008 sel  input  3  opcode: 000 pass A, 001 add, 010 sub, 011 div, 100 mod, 101 shl1, 110 shr1, 111 A>B.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 out  output  WIDTH+1  result.
REQ-012 zero  output  1  out equals 0.
REQ-013 err  output  1  divide or modulo by zero occurred for this result.

Function
REQ-014 Transfer on in_valid && in_ready: a, b and sel are captured; inputs are otherwise ignored.
REQ-015 FSM states: IDLE (in_ready=1, out_valid=0), DIV (both 0), DONE (in_ready=0, out_valid=1).
REQ-016 IDLE -> DONE on accept for every opcode except div/mod with b!=0, so out_valid rises exactly 1 cycle after the accept edge.
REQ-017 IDLE -> DIV on accept of div/mod with b!=0; the divider resolves one quotient bit per cycle; DIV -> DONE after WIDTH cycles, so out_valid rises WIDTH+1 cycles after accept.
REQ-018 DONE -> IDLE on out_ready; out, zero and err are held stable while out_valid=1 && !out_ready.
REQ-019 No overlap: a new operation cannot be accepted in the cycle a result is consumed; in_ready returns 1 the cycle after DONE exits.
REQ-020 Arithmetic on zero-extended WIDTH+1 bits: add = a+b with carry in MSB; sub = a-b modulo 2^(WIDTH+1), so MSB=1 indicates borrow.
REQ-021 div = floor(a/b); mod = a mod b; both zero-extended into out.
REQ-022 shl1 = {a,1'b0} (bit shifted out kept in MSB); shr1 = a>>1; A>B = 1 if a>b else 0; pass A = a.
REQ-023 Divide or modulo by zero: no DIV state; div gives out = {1'b0, all ones}; mod gives out = a; err=1; latency 1.
REQ-024 err=0 for every other result; zero is computed from the final out value.
REQ-025 Illegal sel is not possible (3-bit fully decoded); there is no default-result path beyond REQ-022.

Reset
REQ-026 rst takes priority over all other inputs and is sampled on the clk edge.
REQ-027 After reset: state=IDLE, in_ready=1, out_valid=0, out=0, zero=0, err=0, divider counter=0.
REQ-028 Reset asserted in DIV or DONE aborts the operation; the pending result is discarded and never presented.

Structure
REQ-029 Package alu_pkg holds the opcode constants (OP_PASS..OP_GT) and the state enum (IDLE, DIV, DONE).
REQ-030 The restoring divider is one sub-module, alu_div_iter, with start/busy/done, quotient and remainder outputs, parametrised by WIDTH.
REQ-031 All registers are in clk-domain always blocks with synchronous rst; no latches; no combinational path from in_valid to out_valid.

Verification (WIDTH=8)
REQ-032 add a=200 b=100 -> out_valid 1 cycle after accept, out=9'h12C, zero=0, err=0.
REQ-033 sub a=5 b=7 -> out=9'h1FE; shl1 a=8'h81 -> out=9'h102; A>B a=3 b=3 -> out=0, zero=1.
REQ-034 div a=200 b=7 -> out_valid 9 cycles after accept, out=28; mod a=200 b=7 -> out=4; in_ready=0 throughout.
REQ-035 div a=9 b=0 -> out=9'h0FF, err=1 after 1 cycle; mod a=9 b=0 -> out=9, err=1.
REQ-036 out_ready held low 5 cycles in DONE -> out, zero and err stable; in_valid pulses ignored; in_ready rises 1 cycle after out_ready.
REQ-037 rst pulsed 3 cycles into a div -> next cycle out_valid=0, in_ready=1; a following add 1+1 returns out=2.
